tmds_rx_decoder: RTL

TMDS_RX_DECODER -- requirements
Module: tmds_rx_decoder

---
 rtl/tmds_rx_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder for one channel: word alignment via bitslip, control token and data decode.
// Define TMDS_ERR_CNT_EN to add the saturating lock-loss counter output err_cnt.
module tmds_rx_decoder #(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 4
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  tmds_sym,
  output logic        bitslip,
  output logic        aligned,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de_out,
`ifdef TMDS_ERR_CNT_EN
  output logic [15:0] err_cnt,
`endif
  output logic [1:0]  state_dbg
);

  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int TO_W   = (SEARCH_TIMEOUT > 2) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int WAIT_W = (SLIP_WAIT > 2) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [9:0]          sym_q;
  logic [RUN_W-1:0]    run_cnt, run_next;
  logic [TO_W-1:0]     to_cnt, to_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic [1:0]          last_code;
  logic                is_tok;
  logic [1:0]          tok_code;
  logic                run_hit;
  logic                to_expired;
  logic                clear_run;
  logic [7:0]          d, dec;
  logic [7:0]          data_r;
  logic [1:0]          ctrl_r;
  logic                de_r;

  // Stage 1: capture the raw symbol
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sym_q <= '0;
    else            sym_q <= tmds_sym;
  end

  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (sym_q)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
  end

  always_comb begin
    d      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // A run counter of zero means the previous symbol was data, so any token starts a new run
  always_comb begin
    run_next = '0;
    if (is_tok) begin
      if (run_cnt != '0 && tok_code == last_code)
        run_next = (run_cnt == RUN_W'(TOKEN_RUN)) ? run_cnt : run_cnt + RUN_W'(1);
      else
        run_next = RUN_W'(1);
    end
  end

  assign run_hit    = (run_next == RUN_W'(TOKEN_RUN));
  assign to_expired = (to_cnt == TO_W'(SEARCH_TIMEOUT - 1));

  // Run completion is tested before timeout so a simultaneous expiry never slips or drops lock
  always_comb begin
    state_next = state;
    to_next    = to_cnt;
    wait_next  = wait_cnt;
    clear_run  = 1'b0;
    bitslip    = 1'b0;
    case (state)
      SEARCH: begin
        if (run_hit) begin
          state_next = LOCKED;
          to_next    = '0;
        end else if (to_expired) begin
          state_next = SLIP;
          to_next    = '0;
        end else begin
          to_next = to_cnt + TO_W'(1);
        end
      end
      SLIP: begin
        bitslip    = 1'b1;
        clear_run  = 1'b1;
        to_next    = '0;
        wait_next  = '0;
        state_next = SETTLE;
      end
      SETTLE: begin
        clear_run = 1'b1;
        to_next   = '0;
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          wait_next  = '0;
          state_next = SEARCH;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      LOCKED: begin
        if (run_hit) begin
          to_next = '0;
        end else if (to_expired) begin
          to_next    = '0;
          state_next = SEARCH;
        end else begin
          to_next = to_cnt + TO_W'(1);
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      to_cnt    <= '0;
      wait_cnt  <= '0;
      last_code <= 2'b00;
    end else begin
      state    <= state_next;
      run_cnt  <= clear_run ? '0 : run_next;
      to_cnt   <= to_next;
      wait_cnt <= wait_next;
      if (is_tok) last_code <= tok_code;
    end
  end

  // Stage 2: decoded symbol; ctrl holds through data periods
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_r <= '0;
      ctrl_r <= '0;
      de_r   <= 1'b0;
    end else if (is_tok) begin
      data_r <= '0;
      ctrl_r <= tok_code;
      de_r   <= 1'b0;
    end else begin
      data_r <= dec;
      de_r   <= 1'b1;
    end
  end

  assign aligned   = (state == LOCKED);
  assign data_out  = aligned ? data_r : 8'h00;
  assign ctrl_out  = aligned ? ctrl_r : 2'b00;
  assign de_out    = aligned & de_r;
  assign state_dbg = state;

`ifdef TMDS_ERR_CNT_EN
  logic lock_lost;
  assign lock_lost = (state == LOCKED) && (state_next == SEARCH);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                           err_cnt <= '0;
    else if (lock_lost && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule
